bcd_disp_loader: RTL and testbench

Sequential binary-to-BCD loader for the multiplexed 7-segment display path. It accepts a binary value over a valid/ready handshake, converts it serially with shift-add-3 (double-dabble), one bit per clock, and atomically updates a held packed-BCD register. That register drives the display multiplexer's BCD data input. It also produces an overflow flag and a leading-zero blank mask.

---
 rtl/bcd_disp_loader_pkg.sv | 35 +++
 rtl/bcd_disp_loader_adj.sv | 15 +
 rtl/bcd_disp_loader.sv | 135 +++++++++++++
 tb/tb_bcd_disp_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_loader_pkg.sv
// bcd_disp_loader_pkg
// Shared definitions for the binary-to-BCD display loader:
//   - FSM state encoding (IDLE, SHIFT, LOAD)
//   - clogb2() : bit width needed for the conversion bit counter
//   - max_disp(): largest value representable on n decimal digits (10^n-1)
`timescale 1ns/1ps
package bcd_disp_loader_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_LOAD_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_LOAD  = ST_LOAD_ENC
    } state_t;

    // ceil(log2(n)), never less than 1 so a counter always has a bit
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // 10^n - 1
    function automatic int max_disp(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/bcd_disp_loader_adj.sv
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD nibble that is >= 5 so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   i_nib : input  [3:0] scratch nibble
//   o_nib : output [3:0] corrected nibble
`timescale 1ns/1ps
module bcd_digit_adj (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bcd_disp_loader.sv
// bcd_disp_loader
// Serial binary-to-BCD loader for the multiplexed 7-segment display path.
// Accepts a binary value over valid/ready, runs one double-dabble iteration
// per clock, then atomically updates the held BCD / blank / overflow outputs.
// Ports:
//   clk_i       : clock
//   i_rst       : asynchronous reset, active low
//   i_bin_data  : binary value to display (BIN_W bits)
//   i_bin_valid : source has a value
//   i_lz_en     : leading-zero blanking enable, sampled with the handshake
//   o_bin_ready : loader idle and able to accept
//   o_bcd_data  : packed BCD, nibble DIS_NUM-1 is the most significant digit
//   o_blank     : per-digit blank mask
//   o_ovf       : last loaded value exceeded 10^DIS_NUM-1
//   o_busy      : conversion in progress
//   o_update    : one-cycle pulse after the outputs change
`timescale 1ns/1ps
module bcd_disp_loader
    import bcd_disp_loader_pkg::*;
#(
    parameter int DIS_NUM = 4,
    parameter int BIN_W   = 14
) (
    input  logic                   clk_i,
    input  logic                   i_rst,
    input  logic [BIN_W-1:0]       i_bin_data,
    input  logic                   i_bin_valid,
    input  logic                   i_lz_en,
    output logic                   o_bin_ready,
    output logic [4*DIS_NUM-1:0]   o_bcd_data,
    output logic [DIS_NUM-1:0]     o_blank,
    output logic                   o_ovf,
    output logic                   o_busy,
    output logic                   o_update
);

    localparam int          CNT_W   = clogb2(BIN_W);
    localparam int          SCR_W   = 4 * DIS_NUM;
    localparam int unsigned MAX_VAL = max_disp(DIS_NUM);

    state_t              r_state, w_next;
    logic [SCR_W-1:0]    r_scr, w_adj, r_bcd;
    logic [BIN_W-1:0]    r_bin;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_lz, r_ovf_pend, r_ovf, r_update;
    logic [DIS_NUM-1:0]  r_blank, w_blank;
    logic                w_hs, w_ovf_in, w_run;

    assign w_hs     = i_bin_valid && (r_state == ST_IDLE);
    assign w_ovf_in = 32'(i_bin_data) > MAX_VAL;

    // one correction unit per scratch digit
    for (genvar g = 0; g < DIS_NUM; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_nib (r_scr[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_bin_valid)       w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == '0)       w_next = ST_LOAD;
            ST_LOAD:                         w_next = ST_IDLE;
            default:                         w_next = ST_IDLE;
        endcase
    end

    // Blank mask: walk down from the MSD while digits stay zero. Digit 0 is
    // excluded so a zero value still shows one '0'.
    always_comb begin
        w_blank = '0;
        w_run   = r_lz;
        for (int k = DIS_NUM - 1; k >= 1; k--) begin
            w_run      = w_run && (r_scr[4*k +: 4] == 4'd0);
            w_blank[k] = w_run;
        end
    end

    // Conversion datapath and held outputs
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            r_bin      <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_lz       <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= '0;
            r_ovf      <= 1'b0;
            r_update   <= 1'b0;
        end else begin
            r_update <= (r_state == ST_LOAD);
            if (w_hs) begin
                r_bin      <= i_bin_data;
                r_lz       <= i_lz_en;
                r_ovf_pend <= w_ovf_in;
                r_scr      <= '0;
                r_cnt      <= CNT_W'(BIN_W - 1);
            end else if (r_state == ST_SHIFT) begin
                // adjust then shift {scratch, bin} left; scratch MSB drops
                r_scr <= {w_adj[SCR_W-2:0], r_bin[BIN_W-1]};
                r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
            end else if (r_state == ST_LOAD) begin
                if (r_ovf_pend) begin
                    // scratch may be corrupted on overflow; show all nines
                    r_bcd   <= {DIS_NUM{4'h9}};
                    r_ovf   <= 1'b1;
                    r_blank <= '0;
                end else begin
                    r_bcd   <= r_scr;
                    r_ovf   <= 1'b0;
                    r_blank <= w_blank;
                end
            end
        end
    end

    assign o_bin_ready = (r_state == ST_IDLE);
    assign o_busy      = !o_bin_ready;
    assign o_bcd_data  = r_bcd;
    assign o_blank     = r_blank;
    assign o_ovf       = r_ovf;
    assign o_update    = r_update;

endmodule

// File: tb/tb_bcd_disp_loader.sv
// tb_bcd_disp_loader
// Directed bench for bcd_disp_loader with hand-computed expected values.
`timescale 1ns/1ps
module tb_bcd_disp_loader;

    logic        clk_i = 1'b0;
    logic        i_rst;
    logic [13:0] i_bin_data;
    logic        i_bin_valid;
    logic        i_lz_en;
    logic        o_bin_ready;
    logic [15:0] o_bcd_data;
    logic [3:0]  o_blank;
    logic        o_ovf;
    logic        o_busy;
    logic        o_update;

    int checks   = 0;
    int failures = 0;

    bcd_disp_loader #(.DIS_NUM(4), .BIN_W(14)) dut (
        .clk_i       (clk_i),
        .i_rst       (i_rst),
        .i_bin_data  (i_bin_data),
        .i_bin_valid (i_bin_valid),
        .i_lz_en     (i_lz_en),
        .o_bin_ready (o_bin_ready),
        .o_bcd_data  (o_bcd_data),
        .o_blank     (o_blank),
        .o_ovf       (o_ovf),
        .o_busy      (o_busy),
        .o_update    (o_update)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one value, wait for its o_update; returns edges from handshake
    // to update (-1 on timeout) and number of busy cycles sampled.
    task automatic send(input logic [13:0] v, input logic lz,
                        output int lat, output int busy_n);
        int n;
        i_bin_data  = v;
        i_lz_en     = lz;
        i_bin_valid = 1'b1;
        n = 0;
        while (!o_bin_ready && n < 40) begin
            @(posedge clk_i); #1; n++;
        end
        lat    = -1;
        busy_n = 0;
        if (!o_bin_ready) begin
            i_bin_valid = 1'b0;
            return;
        end
        @(posedge clk_i); #1;          // handshake edge E0
        i_bin_valid = 1'b0;
        busy_n = int'(o_busy);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            busy_n += int'(o_busy);
            if (o_update) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, bn;
    int hs_cnt, upd_cnt, hold_bad, upd_seen;
    int hs_e [2];
    logic hs;

    initial begin
        i_rst       = 1'b0;
        i_bin_data  = '0;
        i_bin_valid = 1'b0;
        i_lz_en     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_bcd",   32'(o_bcd_data), 32'h0);
        check("rst_blank", 32'(o_blank),    32'h0);
        check("rst_ovf",   32'(o_ovf),      32'h0);
        check("rst_upd",   32'(o_update),   32'h0);
        check("rst_busy",  32'(o_busy),     32'h0);
        #2 i_rst = 1'b1;
        @(posedge clk_i); #1;
        check("rst_ready", 32'(o_bin_ready), 32'h1);

        // 1234, no blanking: latency and busy window
        send(14'd1234, 1'b0, lat, bn);
        check("1234_lat",   32'(lat),        32'd15);
        check("1234_busy",  32'(bn),         32'd15);
        check("1234_bcd",   32'(o_bcd_data), 32'h1234);
        check("1234_blank", 32'(o_blank),    32'h0);
        check("1234_ovf",   32'(o_ovf),      32'h0);
        @(posedge clk_i); #1;
        check("upd_pulse1", 32'(o_update),   32'h0);

        // leading-zero blanking
        send(14'd42, 1'b1, lat, bn);
        check("42_lat",   32'(lat),        32'd15);
        check("42_bcd",   32'(o_bcd_data), 32'h0042);
        check("42_blank", 32'(o_blank),    32'b1100);
        send(14'd0, 1'b1, lat, bn);
        check("0_bcd",   32'(o_bcd_data), 32'h0000);
        check("0_blank", 32'(o_blank),    32'b1110);

        // overflow boundary
        send(14'd9999, 1'b0, lat, bn);
        check("9999_bcd", 32'(o_bcd_data), 32'h9999);
        check("9999_ovf", 32'(o_ovf),      32'h0);
        send(14'd10000, 1'b1, lat, bn);
        check("10000_bcd",   32'(o_bcd_data), 32'h9999);
        check("10000_ovf",   32'(o_ovf),      32'h1);
        check("10000_blank", 32'(o_blank),    32'h0);
        send(14'd16383, 1'b0, lat, bn);
        check("16383_bcd", 32'(o_bcd_data), 32'h9999);
        check("16383_ovf", 32'(o_ovf),      32'h1);
        send(14'd5, 1'b0, lat, bn);
        check("5_ovf_clr", 32'(o_ovf),      32'h0);
        check("5_bcd",     32'(o_bcd_data), 32'h0005);
        @(posedge clk_i); #1;

        // back-to-back: valid held high, data wiggled while ready is low
        i_bin_data  = 14'd7;
        i_lz_en     = 1'b0;
        i_bin_valid = 1'b1;
        hs_cnt = 0; upd_cnt = 0; hold_bad = 0; upd_seen = 0;
        hs_e[0] = 0; hs_e[1] = 0;
        for (int k = 1; k <= 60 && upd_cnt < 2; k++) begin
            hs = i_bin_valid && o_bin_ready;
            @(posedge clk_i); #1;
            if (hs) begin
                if (hs_cnt < 2) hs_e[hs_cnt] = k;
                hs_cnt++;
                if (hs_cnt == 1) i_bin_data = 14'd3333;
                if (hs_cnt == 2) i_bin_valid = 1'b0;
            end
            if (k == 6) i_bin_data = 14'd8;
            if (o_update) begin
                upd_cnt++;
                if (upd_cnt == 1) check("b2b_first", 32'(o_bcd_data), 32'h0007);
                if (upd_cnt == 2) check("b2b_second", 32'(o_bcd_data), 32'h0008);
            end else if (upd_cnt == 1 && o_bcd_data !== 16'h0007) begin
                hold_bad++;
            end
        end
        i_bin_valid = 1'b0;
        check("b2b_hs_cnt", 32'(hs_cnt),          32'd2);
        check("b2b_hs_gap", 32'(hs_e[1] - hs_e[0]), 32'd16);
        check("b2b_upd",    32'(upd_cnt),         32'd2);
        check("b2b_hold",   32'(hold_bad),        32'd0);

        // async reset in the middle of a conversion
        @(posedge clk_i); #1;
        i_bin_data  = 14'd5678;
        i_bin_valid = 1'b1;
        @(posedge clk_i); #1;          // handshake (loader idle)
        i_bin_valid = 1'b0;
        check("mid_busy", 32'(o_busy), 32'h1);
        repeat (5) @(posedge clk_i);
        #3 i_rst = 1'b0;
        #1;
        check("mid_rst_bcd",  32'(o_bcd_data), 32'h0);
        check("mid_rst_busy", 32'(o_busy),     32'h0);
        check("mid_rst_upd",  32'(o_update),   32'h0);
        repeat (2) @(posedge clk_i);
        #3 i_rst = 1'b1;
        @(posedge clk_i); #1;
        check("mid_rst_ready", 32'(o_bin_ready), 32'h1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_i); #1;
            if (o_update) upd_seen++;
        end
        check("mid_rst_noupd", 32'(upd_seen),   32'd0);
        check("mid_rst_hold",  32'(o_bcd_data), 32'h0);
        send(14'd321, 1'b0, lat, bn);
        check("321_lat", 32'(lat),        32'd15);
        check("321_bcd", 32'(o_bcd_data), 32'h0321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
